// File: rtl/gem_ext_fifo_tx_pktbuf.sv
// gem_ext_fifo_tx_pktbuf
// Store-and-forward packet buffer in front of the GEM external-FIFO transmit
// adapter. A frame is offered downstream only once it is completely stored, so
// the MAC never sees a mid-frame stall. Errored frames (tuser on any beat) and
// frames larger than the whole buffer are discarded on ingress.
//
// Build option: define GEM_TX_PKTBUF_PAD_EN to zero-pad frames shorter than
// 60 bytes on egress. Without it, frames leave exactly as stored.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last,user}  ingress byte stream (tuser = error)
//   m_axis_t{data,valid,ready,last}       egress byte stream
//   frame_count              committed frames not yet fully read
//   drop_count               discarded frames, saturating
//   empty                    no committed frame and read side idle
//
// Write FSM  state   | meaning
//            W_IDLE  | between frames
//            W_FILL  | storing a frame
//            W_DISC  | frame exceeded buffer, dropping beats until tlast
// Read FSM   R_IDLE  | nothing committed to send
//            R_PREF  | first RAM read of a frame is issued
//            R_STRM  | reads issued as skid space allows, until frame(s) sent
module gem_ext_fifo_tx_pktbuf #(
    parameter int DEPTH_LOG2 = 11,
    parameter int FCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [FCNT_W-1:0] frame_count,
    output logic [15:0]       drop_count,
    output logic              empty
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]     CAP    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [FCNT_W-1:0] FC_MAX = {FCNT_W{1'b1}};

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISC} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_PREF, R_STRM} rd_state_t;

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              bad_q, bad_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [15:0]       drop_q, drop_d;
    logic [8:0]        mem [2**DEPTH_LOG2];
    logic [8:0]        ram_q;
    logic              rdv_q;
    logic [8:0]        ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]        ocnt_q, ocnt_d;

    logic       full, s_acc, mem_we, commit, drop_inc, rd_issue;
    logic       out_valid, out_last, hs, pop, frame_end;
    logic [7:0] out_data;
    logic [2:0] occ;

    assign full          = (wr_ptr_q - rd_ptr_q) == CAP;
    assign s_axis_tready = !rst && ((wr_state_q == W_DISC) || (!full && fcnt_q != FC_MAX));
    assign s_acc         = s_axis_tvalid && s_axis_tready;

    // Write side
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        bad_d        = bad_q;
        mem_we       = 1'b0;
        commit       = 1'b0;
        drop_inc     = 1'b0;
        case (wr_state_q)
            W_DISC: begin
                if (s_acc && s_axis_tlast) begin
                    wr_state_d = W_IDLE;
                    drop_inc   = 1'b1;
                end
            end
            default: begin
                if (s_acc) begin
                    mem_we = 1'b1;
                    if (s_axis_tlast) begin
                        wr_state_d = W_IDLE;
                        bad_d      = 1'b0;
                        if (bad_q || s_axis_tuser) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 1'b1;
                        end else begin
                            wr_ptr_d     = wr_ptr_q + PW'(1);
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            commit       = 1'b1;
                        end
                    end else begin
                        wr_state_d = W_FILL;
                        wr_ptr_d   = wr_ptr_q + PW'(1);
                        bad_d      = bad_q || s_axis_tuser;
                    end
                end else if (full && fcnt_q == '0) begin
                    // Nothing committed to drain, so this frame can never fit.
                    wr_state_d = W_DISC;
                    wr_ptr_d   = commit_ptr_q;
                    bad_d      = 1'b0;
                end
            end
        endcase
        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    // Egress formatting
`ifdef GEM_TX_PKTBUF_PAD_EN
    logic       pad_q, pad_d;
    logic [6:0] bcnt_q, bcnt_d;
    logic       short_frm;

    assign short_frm = bcnt_q < 7'd59;
    assign out_valid = pad_q || (ocnt_q != 2'd0);
    assign out_data  = pad_q ? 8'h00 : ent0_q[7:0];
    assign out_last  = pad_q ? (bcnt_q == 7'd59) : (ent0_q[8] && !short_frm);
    assign hs        = out_valid && m_axis_tready;
    assign pop       = hs && !pad_q;

    always_comb begin
        pad_d  = pad_q;
        bcnt_d = bcnt_q;
        if (hs) begin
            if (pad_q) begin
                if (out_last) pad_d = 1'b0;
            end else if (ent0_q[8] && short_frm) begin
                pad_d = 1'b1;
            end
            // Saturate so long frames never wrap back into the short range.
            if (out_last)                bcnt_d = 7'd0;
            else if (bcnt_q != 7'd127)   bcnt_d = bcnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q  <= 1'b0;
            bcnt_q <= 7'd0;
        end else begin
            pad_q  <= pad_d;
            bcnt_q <= bcnt_d;
        end
    end
`else
    assign out_valid = ocnt_q != 2'd0;
    assign out_data  = ent0_q[7:0];
    assign out_last  = ent0_q[8];
    assign hs        = out_valid && m_axis_tready;
    assign pop       = hs;
`endif

    assign frame_end = hs && out_last;

    // Read side: keep skid occupancy plus the in-flight RAM read at most 2.
    always_comb begin
        occ        = 3'(ocnt_q) + 3'(rdv_q) - 3'(pop);
        rd_issue   = (rd_state_q != R_IDLE) && (rd_ptr_q != commit_ptr_q) && (occ < 3'd2);
        rd_ptr_d   = rd_ptr_q + PW'(rd_issue);
        fcnt_d     = fcnt_q + FCNT_W'(commit) - FCNT_W'(frame_end);
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (fcnt_q != '0) rd_state_d = R_PREF;
            R_PREF:  rd_state_d = R_STRM;
            default: if (frame_end && fcnt_d == '0) rd_state_d = R_IDLE;
        endcase

        ent0_d = ent0_q;
        ent1_d = ent1_q;
        ocnt_d = ocnt_q;
        case ({rdv_q, pop})
            2'b01: begin
                ent0_d = ent1_q;
                ocnt_d = ocnt_q - 2'd1;
            end
            2'b10: begin
                if (ocnt_q == 2'd0) ent0_d = ram_q;
                else                ent1_d = ram_q;
                ocnt_d = ocnt_q + 2'd1;
            end
            2'b11: begin
                if (ocnt_q == 2'd1) begin
                    ent0_d = ram_q;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = ram_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
        if (rd_issue) ram_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q   <= W_IDLE;
            rd_state_q   <= R_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            bad_q        <= 1'b0;
            fcnt_q       <= '0;
            drop_q       <= '0;
            rdv_q        <= 1'b0;
            ent0_q       <= '0;
            ent1_q       <= '0;
            ocnt_q       <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            bad_q        <= bad_d;
            fcnt_q       <= fcnt_d;
            drop_q       <= drop_d;
            rdv_q        <= rd_issue;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            ocnt_q       <= ocnt_d;
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_valid && out_last;
    assign frame_count   = fcnt_q;
    assign drop_count    = drop_q;
    assign empty         = (fcnt_q == '0) && (rd_state_q == R_IDLE);
endmodule
